data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-requester arbiter that shares the single-ported 256×8 `data_mem` between the processor core (port 0) and a loader/debug master (port 1). Each cycle it grants at most one requester. It drives the memory's address, read-enable, write-enable and write-data lines, and registers read data back to the winner. Port 0 has fixed priority. A starvation counter guarantees port 1 a grant within a bounded number of contended cycles.

## Interface
Parameters:
- `AW`, 8, address width (matches `data_mem` DataAddress)
- `DW`, 8, data width
- `MAX_WAIT`, 4, contended cycles port 1 may lose before it is forced a grant (legal range 1..255)

Ports:
- `CLK`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high reset
- `req0` / `req1`  in  1  request from port 0 / port 1; held with its qualifiers until granted
- `we0` / `we1`  in  1  1 = write, 0 = read
- `addr0` / `addr1`  in  AW  access address
- `wdata0` / `wdata1`  in  DW  write data
- `gnt0` / `gnt1`  out  1  combinational grant; the access executes in this cycle
- `rdata0` / `rdata1`  out  DW  registered read data
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse; `rdataN` is valid
- `mem_addr`  out  AW  to DataAddress
- `mem_read`  out  1  to ReadMem
- `mem_write`  out  1  to WriteMem
- `mem_din`  out  DW  to DataIn
- `mem_dout`  in  DW  from DataOut; tristated when `mem_read` = 0
- `conflict_cnt`  out  16  count of cycles in which both ports requested; saturates at 0xFFFF

## Operation
- Arbitration is combinational from `req0`, `req1`, `reset` and the starvation state.
  - `reset` = 1: `gnt0` = `gnt1` = 0.
  - Only one port requesting: that port is granted.
  - Both requesting: port 0 wins, unless `wait1` = `MAX_WAIT`, in which case port 1 wins.
- Starvation counter `wait1` (width ⌈log2(MAX_WAIT+1)⌉, reset 0):
  - Increments on each cycle where `req1` = 1 and `gnt1` = 0.
  - Clears on `gnt1` = 1 or on `req1` = 0.
  - Never exceeds `MAX_WAIT`.
- Memory drive for the granted port N:
  - `mem_addr` = `addrN`, `mem_din` = `wdataN`.
  - `mem_write` = `weN`, `mem_read` = !`weN`.
- No grant: `mem_read` = `mem_write` = 0, `mem_addr` = 0, `mem_din` = 0. Memory outputs Z.
- Read grant to port N: at that posedge `rdataN` ← `mem_dout` and `rvalidN` ← 1. `rvalidN` returns to 0 on the next cycle unless another read is granted.
- `rdataN` holds its last value between reads; it is never loaded with Z.
- Write grant: the memory commits at the same posedge. `rvalidN` stays 0.
- Requester protocol:
  - Hold `req`/`we`/`addr`/`wdata` stable until the cycle where `gnt` = 1.
  - The next request may be presented in the following cycle.
  - If `req` stays high after a grant, that is a new access.
- `conflict_cnt` increments on cycles with `req0` & `req1` & !`reset`.
- No state machine beyond `wait1`. Arbitration is memoryless otherwise.

## Timing
- Grant latency: 0 cycles (same cycle as request if it wins).
- Write latency: commits at the end of the grant cycle. A read of the same address granted in the next cycle returns the new data.
- Read latency: `rvalidN`/`rdataN` assert 1 cycle after the grant cycle.
- Throughput: one access per cycle in total across both ports.
- Worst-case port 1 wait under continuous port 0 traffic: `MAX_WAIT` cycles, granted on cycle `MAX_WAIT`+1.
- Reset values: `rdata0/1` = 0, `rvalid0/1` = 0, `wait1` = 0, `conflict_cnt` = 0. Combinational outputs are 0 while `reset` = 1.
- Reset asserted in a grant cycle: the grant is suppressed and no memory write occurs. `rvalid` is 0 on the following cycle.
- Same address, both ports writing in one cycle: only the winner writes. The loser retries and overwrites on a later cycle.
- `MAX_WAIT` = 1 degenerates to alternation under contention: port 1 at most every 2nd contended cycle.

## Test plan
- Single read: preload M[0x10] = 0xA5; `req0`=1, `we0`=0, `addr0`=0x10 for one cycle -> `gnt0`=1 that cycle; next cycle `rvalid0`=1, `rdata0`=0xA5, `rvalid1`=0.
- Write then read, port 1: write 0x3C to 0x80, then read 0x80 in the next cycle -> `gnt1` high both cycles, `rdata1`=0x3C with `rvalid1` pulse; `mem_write` high only in the first cycle.
- Contention, `MAX_WAIT`=4: `req0` and `req1` held high continuously -> `gnt0` cycles 1–4, `gnt1` cycle 5, then `gnt0` resumes; `conflict_cnt` = 5 after 5 cycles.
- Simultaneous write to 0x20: port 0 writes 0x11, port 1 writes 0x22 -> port 0 wins; port 1 is granted next cycle; a final read of 0x20 returns 0x22.
- Reset mid-access: assert `reset` in the cycle `req0` writes 0x77 to 0x05 (old value 0x00) -> `gnt0`=0, `mem_write`=0; after release, a read of 0x05 returns 0x00; all counters are 0.
- Idle: no requests for 10 cycles -> `mem_read` = `mem_write` = 0, `rvalid` = 0, `rdata` unchanged, `wait1` = 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares the single-ported 256x8 data_mem between the processor core (port 0)
// and a loader/debug master (port 1). At most one port is granted per cycle.
// Port 0 has fixed priority. A starvation counter forces a port 1 grant after
// MAX_WAIT contended cycles.
//
// Ports:
//   CLK, reset              clock, synchronous active-high reset
//   req/we/addr/wdata 0,1   request, write flag, address, write data per port
//   gnt0/gnt1               combinational grant (the access executes this cycle)
//   rdata0/1, rvalid0/1     registered read data and its one-cycle valid pulse
//   mem_addr/read/write/din drive to data_mem; mem_dout is read data from it
//   conflict_cnt            saturating count of cycles with both ports requesting
module data_mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic [15:0]   conflict_cnt
);

  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MaxWaitL = WW'(MAX_WAIT);

  logic [WW-1:0] wait1_q, wait1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [15:0]   conflict_q, conflict_d;
  logic          starved;

  // Port 1 wins a contended cycle only once it has lost MAX_WAIT of them.
  always_comb begin
    starved = (wait1_q == MaxWaitL);
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (!reset) begin
      gnt0 = req0 & ~(req1 & starved);
      gnt1 = req1 & (~req0 | starved);
    end
  end

  // Memory lines follow the winner; with no grant everything is driven to 0
  // so the memory tristates its output.
  always_comb begin
    mem_addr  = '0;
    mem_din   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_din   = wdata0;
      mem_write = we0;
      mem_read  = ~we0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_din   = wdata1;
      mem_write = we1;
      mem_read  = ~we1;
    end
  end

  // Next-state: starvation counter, read-data capture and conflict counter.
  // rdata is only loaded on a read grant, when the memory is actively driving.
  always_comb begin
    wait1_d = wait1_q;
    if (!req1 || gnt1) begin
      wait1_d = '0;
    end else if (!starved) begin
      wait1_d = wait1_q + WW'(1);
    end

    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    rdata0_d  = rvalid0_d ? mem_dout : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_dout : rdata1_q;

    conflict_d = conflict_q;
    if (req0 && req1 && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wait1_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      conflict_q <= '0;
    end else begin
      wait1_q    <= wait1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      conflict_q <= conflict_d;
    end
  end

  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign rvalid0      = rvalid0_q;
  assign rvalid1      = rvalid1_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
// Directed bench for data_mem_arbiter with MAX_WAIT = 4. Includes a small
// 256x8 memory model with asynchronous read and posedge write, tristated
// output when not read-enabled.
module tb_data_mem_arbiter;

  logic        CLK = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [7:0]  addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0]  rdata0, rdata1;
  logic [7:0]  mem_addr, mem_din;
  wire  [7:0]  mem_dout;
  logic        mem_read, mem_write;
  logic [15:0] conflict_cnt;

  int total = 0;
  int bad   = 0;

  logic       preloadEn = 1'b0;
  logic [7:0] memArr [256] = '{default: 8'h00};

  always #5 CLK = ~CLK;

  // Memory model standing in for data_mem.
  always @(posedge CLK) begin
    if (preloadEn) memArr[8'h10] <= 8'hA5;
    else if (mem_write) memArr[mem_addr] <= mem_din;
  end
  assign mem_dout = mem_read ? memArr[mem_addr] : 8'hzz;

  data_mem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(4)) dut (
    .CLK(CLK), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_din(mem_din), .mem_dout(mem_dout), .conflict_cnt(conflict_cnt)
  );

  task automatic applyStimulus(input logic r0, input logic w0, input logic [7:0] a0,
                               input logic [7:0] d0, input logic r1, input logic w1,
                               input logic [7:0] a1, input logic [7:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    preloadEn = 1'b1;
    tick();
    preloadEn = 1'b0;
    tick();

    // Reset state
    checkOutput("rst_rdata0", 16'(rdata0), 16'h00);
    checkOutput("rst_rvalid0", 16'(rvalid0), 16'h0);
    checkOutput("rst_conflict", conflict_cnt, 16'h0);
    applyStimulus(1, 0, 8'h10, 8'h00, 1, 0, 8'h10, 8'h00);
    #2;
    checkOutput("rst_gnt0", 16'(gnt0), 16'h0);
    checkOutput("rst_gnt1", 16'(gnt1), 16'h0);
    checkOutput("rst_mem_read", 16'(mem_read), 16'h0);
    tick();

    // Single read of preloaded 0x10 from port 0
    reset = 1'b0;
    applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    #2;
    checkOutput("rd_gnt0", 16'(gnt0), 16'h1);
    checkOutput("rd_mem_read", 16'(mem_read), 16'h1);
    checkOutput("rd_mem_addr", 16'(mem_addr), 16'h10);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("rd_rvalid0", 16'(rvalid0), 16'h1);
    checkOutput("rd_rdata0", 16'(rdata0), 16'hA5);
    checkOutput("rd_rvalid1", 16'(rvalid1), 16'h0);
    #2;
    checkOutput("idle_mem_read", 16'(mem_read), 16'h0);
    tick();
    checkOutput("rd_rvalid0_drop", 16'(rvalid0), 16'h0);
    checkOutput("rd_rdata0_hold", 16'(rdata0), 16'hA5);

    // Port 1 writes 0x3C to 0x80, then reads it back
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h80, 8'h3C);
    #2;
    checkOutput("wr1_gnt1", 16'(gnt1), 16'h1);
    checkOutput("wr1_mem_write", 16'(mem_write), 16'h1);
    checkOutput("wr1_mem_din", 16'(mem_din), 16'h3C);
    checkOutput("wr1_mem_addr", 16'(mem_addr), 16'h80);
    tick();
    checkOutput("wr1_rvalid1", 16'(rvalid1), 16'h0);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h80, 8'h00);
    #2;
    checkOutput("rd1_gnt1", 16'(gnt1), 16'h1);
    checkOutput("rd1_mem_write", 16'(mem_write), 16'h0);
    checkOutput("rd1_mem_read", 16'(mem_read), 16'h1);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("rd1_rvalid1", 16'(rvalid1), 16'h1);
    checkOutput("rd1_rdata1", 16'(rdata1), 16'h3C);
    checkOutput("rd1_conflict", conflict_cnt, 16'h0);
    tick();

    // Contention: both read continuously; port 1 forced on cycle 5
    applyStimulus(1, 0, 8'h10, 8'h00, 1, 0, 8'h80, 8'h00);
    for (int c = 1; c <= 5; c++) begin
      #2;
      checkOutput($sformatf("cont_gnt0_c%0d", c), 16'(gnt0), (c < 5) ? 16'h1 : 16'h0);
      checkOutput($sformatf("cont_gnt1_c%0d", c), 16'(gnt1), (c == 5) ? 16'h1 : 16'h0);
      tick();
    end
    checkOutput("cont_conflict5", conflict_cnt, 16'd5);
    checkOutput("cont_rvalid1", 16'(rvalid1), 16'h1);
    checkOutput("cont_rdata1", 16'(rdata1), 16'h3C);
    checkOutput("cont_rvalid0", 16'(rvalid0), 16'h0);
    #2;
    checkOutput("cont_gnt0_c6", 16'(gnt0), 16'h1);
    checkOutput("cont_gnt1_c6", 16'(gnt1), 16'h0);
    tick();
    checkOutput("cont_conflict6", conflict_cnt, 16'd6);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();

    // Simultaneous writes to 0x20: port 0 first, port 1 overwrites
    applyStimulus(1, 1, 8'h20, 8'h11, 1, 1, 8'h20, 8'h22);
    #2;
    checkOutput("sw_gnt0", 16'(gnt0), 16'h1);
    checkOutput("sw_gnt1", 16'(gnt1), 16'h0);
    checkOutput("sw_din0", 16'(mem_din), 16'h11);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h22);
    #2;
    checkOutput("sw_gnt1_next", 16'(gnt1), 16'h1);
    checkOutput("sw_din1", 16'(mem_din), 16'h22);
    tick();
    checkOutput("sw_conflict", conflict_cnt, 16'd7);
    applyStimulus(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("sw_rvalid0", 16'(rvalid0), 16'h1);
    checkOutput("sw_rdata0", 16'(rdata0), 16'h22);
    tick();

    // Reset during a port 0 write of 0x77 to 0x05
    reset = 1'b1;
    applyStimulus(1, 1, 8'h05, 8'h77, 0, 0, 8'h00, 8'h00);
    #2;
    checkOutput("rstw_gnt0", 16'(gnt0), 16'h0);
    checkOutput("rstw_mem_write", 16'(mem_write), 16'h0);
    checkOutput("rstw_mem_addr", 16'(mem_addr), 16'h00);
    tick();
    reset = 1'b0;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("rstw_rvalid0", 16'(rvalid0), 16'h0);
    checkOutput("rstw_conflict", conflict_cnt, 16'h0);
    checkOutput("rstw_rdata1", 16'(rdata1), 16'h00);
    applyStimulus(1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("rstw_rd_rvalid0", 16'(rvalid0), 16'h1);
    checkOutput("rstw_rd_rdata0", 16'(rdata0), 16'h00);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
    tick();
    checkOutput("pre_idle_rdata1", 16'(rdata1), 16'hA5);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      #2;
      checkOutput($sformatf("idle_rw_%0d", i), {14'h0, mem_read, mem_write}, 16'h0);
      checkOutput($sformatf("idle_rv_%0d", i), {14'h0, rvalid0, rvalid1}, 16'h0);
      tick();
    end
    checkOutput("idle_rdata0", 16'(rdata0), 16'h00);
    checkOutput("idle_rdata1", 16'(rdata1), 16'hA5);
    checkOutput("idle_wait1", 16'(dut.wait1_q), 16'h0);
    checkOutput("idle_conflict", conflict_cnt, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
